// File: rtl/ram_sync_param.sv
// Parametrised single-port synchronous RAM with per-bit write mask, registered read,
// out-of-range flagging and a sweep engine that rewrites every word after reset or on request.
module ram_sync_param #(
    parameter int                 DATA_W    = 4,
    parameter int                 ADDR_W    = 4,
    parameter int                 DEPTH     = 16,
    parameter logic [DATA_W-1:0]  CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] datain,
    input  logic [DATA_W-1:0] wmask,
    input  logic              csn,
    input  logic              rwn,
    input  logic              clear_req,
    output logic [DATA_W-1:0] dataout,
    output logic              dout_valid,
    output logic              busy,
    output logic              err
);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    // One extra bit so the bound still compares correctly when DEPTH == 2**ADDR_W.
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH-1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_next;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_dataout;
    logic              r_dout_valid;
    logic              r_err;

    logic              w_in_range;
    logic              w_access;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_mem_mask;
    logic [DATA_W-1:0] w_bit_we;
    logic              w_rd_hit;
    logic              w_rd_oor;
    logic              w_dv_next;
    logic              w_err_next;

    assign w_in_range = ({1'b0, addr} < DEPTH_W);
    // A clear request in the same cycle wins over any access.
    assign w_access   = (r_state == ST_IDLE) && !clear_req && !csn;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        case (r_state)
            ST_CLEAR: begin
                if (r_clr_ptr == LAST_PTR) begin
                    w_state_next   = ST_IDLE;
                    w_clr_ptr_next = '0;
                end else begin
                    w_clr_ptr_next = r_clr_ptr + 1'b1;
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    w_state_next   = ST_CLEAR;
                    w_clr_ptr_next = '0;
                end
            end
            default: begin
                w_state_next   = ST_CLEAR;
                w_clr_ptr_next = '0;
            end
        endcase
    end

    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_clr_ptr;
        w_mem_data = CLEAR_VAL;
        w_mem_mask = '1;
        w_rd_hit   = 1'b0;
        w_rd_oor   = 1'b0;
        w_dv_next  = 1'b0;
        w_err_next = 1'b0;
        if (!reset) begin
            if (r_state == ST_CLEAR) begin
                w_mem_we = 1'b1;
            end else if (w_access) begin
                w_err_next = !w_in_range;
                if (rwn) begin
                    w_dv_next = 1'b1;
                    w_rd_hit  = w_in_range;
                    w_rd_oor  = !w_in_range;
                end else if (w_in_range) begin
                    w_mem_we   = 1'b1;
                    w_mem_addr = addr;
                    w_mem_data = datain;
                    w_mem_mask = wmask;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit_we
            assign w_bit_we[gi] = w_mem_we & w_mem_mask[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_W; b++) begin
            if (w_bit_we[b]) begin
                r_mem[w_mem_addr][b] <= w_mem_data[b];
            end
        end
    end

    // Read port sees the array before any same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dataout    <= '0;
            r_dout_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_dout_valid <= w_dv_next;
            r_err        <= w_err_next;
            if (w_rd_hit) begin
                r_dataout <= r_mem[addr];
            end else if (w_rd_oor) begin
                r_dataout <= '0;
            end
        end
    end

    assign dataout    = r_dataout;
    assign dout_valid = r_dout_valid;
    assign err        = r_err;
    assign busy       = (r_state == ST_CLEAR);

endmodule

// File: tb/tb_ram_sync_param.sv
// Directed bench: default 16-word RAM plus a 12-word build (CLEAR_VAL=1010) on shared inputs.
module tb_ram_sync_param;

    logic       clk;
    logic       reset;
    logic [3:0] addr;
    logic [3:0] datain;
    logic [3:0] wmask;
    logic       csn;
    logic       rwn;
    logic       clear_req;

    logic [3:0] dout16, dout12;
    logic       dv16, dv12, busy16, busy12, err16, err12;

    int n_checks = 0;
    int n_err    = 0;

    ram_sync_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(16), .CLEAR_VAL(4'h0)) dut16 (
        .clk(clk), .reset(reset), .addr(addr), .datain(datain), .wmask(wmask),
        .csn(csn), .rwn(rwn), .clear_req(clear_req),
        .dataout(dout16), .dout_valid(dv16), .busy(busy16), .err(err16)
    );

    ram_sync_param #(.DATA_W(4), .ADDR_W(4), .DEPTH(12), .CLEAR_VAL(4'hA)) dut12 (
        .clk(clk), .reset(reset), .addr(addr), .datain(datain), .wmask(wmask),
        .csn(csn), .rwn(rwn), .clear_req(clear_req),
        .dataout(dout12), .dout_valid(dv12), .busy(busy12), .err(err12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       csn;
        logic       rwn;
        logic [3:0] addr;
        logic [3:0] din;
        logic [3:0] mask;
        logic [3:0] exp_dout;
        logic       exp_dv;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic apply(input logic c, input logic r, input logic [3:0] a,
                         input logic [3:0] d, input logic [3:0] m);
        csn    = c;
        rwn    = r;
        addr   = a;
        datain = d;
        wmask  = m;
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge that started a sweep; counts busy cycles with reads probing.
    task automatic wait_sweep(input string name, input int exp_cycles);
        int   cnt = 0;
        logic bad = 1'b0;
        while (busy16 && cnt < 200) begin
            cnt++;
            if (dv16 || err16) bad = 1'b1;
            csn = 1'b0;
            rwn = 1'b1;
            addr = cnt[3:0];
            @(posedge clk);
            #1;
        end
        csn = 1'b1;
        chk({name, "_len"}, cnt, exp_cycles);
        chk({name, "_dv_quiet"}, {31'b0, bad}, 0);
        $display("sweep %s busy_cycles=%0d", name, cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; csn = 1'b1; rwn = 1'b1; addr = '0;
        datain = '0; wmask = '0; clear_req = 1'b0;

        // Reset sweep
        @(posedge clk);
        #1;
        chk("rst_dout", dout16, 0);
        chk("rst_dv", dv16, 0);
        chk("rst_busy", busy16, 1);
        chk("rst_err", err16, 0);
        reset = 1'b0;
        wait_sweep("reset_sweep", 16);

        for (int a = 0; a < 16; a++)
            vecs.push_back('{1'b0, 1'b1, 4'(a), 4'h0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'h4, 4'h5, 4'hF, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h5, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'h4, 4'hA, 4'h3, 4'h5, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h6, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'h4, 4'hF, 4'h0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 4'h6, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 4'h4, 4'h0, 4'h0, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'hF, 4'h9, 4'hF, 4'h6, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h9, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0});
        vecs.push_back('{1'b0, 1'b0, 4'h3, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 4'h3, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 4'h3, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            apply(vecs[i].csn, vecs[i].rwn, vecs[i].addr, vecs[i].din, vecs[i].mask);
            chk($sformatf("vec%0d_dout", i), dout16, vecs[i].exp_dout);
            chk($sformatf("vec%0d_dv", i), dv16, vecs[i].exp_dv);
            chk($sformatf("vec%0d_err", i), err16, vecs[i].exp_err);
            $display("vec %0d csn=%b rwn=%b addr=%h din=%h mask=%h dout=%h dv=%b err=%b",
                     i, vecs[i].csn, vecs[i].rwn, vecs[i].addr, vecs[i].din, vecs[i].mask,
                     dout16, dv16, err16);
        end
        csn = 1'b1;

        // Clear request with a simultaneous write that must be dropped
        clear_req = 1'b1;
        apply(1'b0, 1'b0, 4'h7, 4'h8, 4'hF);
        clear_req = 1'b0;
        chk("clr_busy", busy16, 1);
        chk("clr_dv", dv16, 0);
        wait_sweep("clear_req", 16);
        chk("clr_dout_hold", dout16, 4'hF);
        apply(1'b0, 1'b1, 4'h3, 4'h0, 4'h0);
        chk("clr_rd3", dout16, 4'h0);
        chk("clr_rd3_dv", dv16, 1);
        apply(1'b0, 1'b1, 4'h7, 4'h0, 4'h0);
        chk("clr_rd7", dout16, 4'h0);
        chk("clr_rd7_d12", dout12, 4'hA);

        // Reset at sweep cycle 5 restarts the full sweep
        clear_req = 1'b1;
        apply(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        clear_req = 1'b0;
        chk("mid_busy1", busy16, 1);
        for (int c = 2; c <= 5; c++) begin
            apply(1'b0, 1'b1, 4'(c), 4'h0, 4'h0);
            chk($sformatf("mid_busy%0d", c), busy16, 1);
            chk($sformatf("mid_dv%0d", c), dv16, 0);
        end
        reset = 1'b1;
        apply(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
        reset = 1'b0;
        chk("mid_rst_dout", dout16, 0);
        wait_sweep("mid_reset", 16);

        // Out of range on the 12-word build
        apply(1'b0, 1'b0, 4'hB, 4'h5, 4'hF);
        chk("oor_w11_err", err12, 0);
        apply(1'b0, 1'b1, 4'hB, 4'h0, 4'h0);
        chk("oor_r11_dout", dout12, 4'h5);
        chk("oor_r11_err", err12, 0);
        apply(1'b0, 1'b0, 4'hD, 4'hF, 4'hF);
        chk("oor_w13_err", err12, 1);
        chk("oor_w13_dv", dv12, 0);
        chk("oor_w13_hold", dout12, 4'h5);
        apply(1'b0, 1'b1, 4'hD, 4'h0, 4'h0);
        chk("oor_r13_err", err12, 1);
        chk("oor_r13_dv", dv12, 1);
        chk("oor_r13_dout", dout12, 4'h0);
        chk("oor_r13_err16", err16, 0);
        apply(1'b1, 1'b1, 4'hD, 4'h0, 4'h0);
        chk("oor_idle_err", err12, 0);
        chk("oor_idle_dv", dv12, 0);
        apply(1'b0, 1'b1, 4'hC, 4'h0, 4'h0);
        chk("oor_r12_err", err12, 1);
        for (int a = 0; a < 12; a++) begin
            apply(1'b0, 1'b1, 4'(a), 4'h0, 4'h0);
            chk($sformatf("oor_keep%0d", a), dout12, (a == 11) ? 4'h5 : 4'hA);
            chk($sformatf("oor_keep%0d_err", a), err12, 0);
            $display("d12 read addr=%0d dout=%h err=%b", a, dout12, err12);
        end
        csn = 1'b1;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ram_sync_param.md
# ram_sync_param

Parametrised single-port synchronous RAM, successor to the fixed 16x4 scratch memory in the 4-bit processor simulator. Width, depth and clear value are configurable. Adds a per-bit write mask, a registered read with a valid strobe, out-of-range detection, and a hardware clear engine that sweeps every location after reset or on request. It sits between the CPU datapath and the register/scratch address space.

## Interface

Parameters:

- `DATA_W`, default 4 — data word width in bits.
- `ADDR_W`, default 4 — address width.
- `DEPTH`, default 16 — number of words; legal range 2..2^ADDR_W.
- `CLEAR_VAL`, default 0 — `DATA_W`-bit value written to every location by the clear engine.

Ports:

- `clk`  in  1  — single clock; all logic on rising edge.
- `reset`  in  1  — synchronous, active-high reset.
- `addr`  in  `ADDR_W`  — word address.
- `datain`  in  `DATA_W`  — write data.
- `wmask`  in  `DATA_W`  — per-bit write enable; 1 = bit written.
- `csn`  in  1  — chip select, active low.
- `rwn`  in  1  — 1 = read, 0 = write; sampled only when `csn`=0.
- `clear_req`  in  1  — single-cycle request to start a full clear.
- `dataout`  out  `DATA_W`  — registered read data.
- `dout_valid`  out  1  — one-cycle strobe: `dataout` updated by a read this cycle.
- `busy`  out  1  — clear sweep in progress; accesses ignored.
- `err`  out  1  — one-cycle strobe: access to addr ≥ `DEPTH`.

## Operation

- FSM has two states: CLEAR and IDLE.
- Reset (`reset`=1 at a clock edge):
  - state←CLEAR, clr_ptr←0, `busy`←1.
  - `dataout`←0, `dout_valid`←0, `err`←0.
  - Memory contents are not reset directly; the clear sweep overwrites them.
- CLEAR:
  - Each cycle, mem[clr_ptr]←`CLEAR_VAL` and clr_ptr increments.
  - At clr_ptr = `DEPTH`-1: write that location, then state←IDLE and `busy`←0 on the same edge.
  - All `csn`/`rwn`/`clear_req` inputs are ignored. `dout_valid`=0, `err`=0, `dataout` holds.
- IDLE with `clear_req`=1:
  - state←CLEAR, clr_ptr←0, `busy`←1.
  - Clear has priority: any access presented in the same cycle is dropped, with no write and no `dout_valid`.
- IDLE, `csn`=0, `rwn`=0, addr < `DEPTH` (write):
  - mem[addr] ← (mem[addr] & ~`wmask`) | (`datain` & `wmask`).
  - `wmask`=0 means no change. `dataout` holds, `dout_valid`=0.
- IDLE, `csn`=0, `rwn`=1, addr < `DEPTH` (read):
  - `dataout`←mem[addr] (contents before any same-edge update), `dout_valid`←1.
- IDLE, `csn`=0, addr ≥ `DEPTH`:
  - Write is discarded. A read sets `dataout`←0 and `dout_valid`←1.
  - `err`←1 in both cases.
- IDLE, `csn`=1: no access. `dataout` holds; `dout_valid`=0 and `err`=0.
- `reset` asserted mid-sweep: the sweep restarts from clr_ptr=0 with the full `DEPTH` cycles.

## Timing

- Read latency: 1 cycle. Address is sampled at edge N; `dataout`/`dout_valid` are valid after edge N and until edge N+1.
- `dout_valid` and `err` are single-cycle pulses, re-evaluated every edge.
- Back-to-back accesses are allowed every cycle. A write at edge N followed by a read of the same address at edge N+1 returns the new data.
- Clear duration: exactly `DEPTH` cycles of `busy`=1, counted from the edge that samples `reset` or `clear_req`.
  - First access is accepted at the edge after `busy` falls.
  - Default build: 16 cycles.
- Output reset values: `dataout`=0, `dout_valid`=0, `busy`=1, `err`=0.
- clr_ptr is `ADDR_W` bits wide and never exceeds `DEPTH`-1.

## Test plan

- **Reset sweep:** hold `reset` 1 cycle, then release. Required: `busy`=1 for exactly 16 cycles, then 0. Reading addresses 0..15 returns 0000 each, with `dout_valid`=1 one cycle after each address.
- **Write/read:** write `datain`=0101, `wmask`=1111 to addr 0100, then read 0100 next cycle. Required: `dataout`=0101, `dout_valid`=1 one cycle after the read edge.
- **Masked write:** addr 0100 holds 0101; write `datain`=1010, `wmask`=0011. Readback required: 0110.
- **Clear request:** write 1111 to addr 0011. Pulse `clear_req` together with a write of 1000 to addr 0111. Required: `busy`=1 for 16 cycles and that write dropped. Afterwards, addr 0011 and 0111 read `CLEAR_VAL`=0000.
- **Access during busy / reset mid-clear:** issue reads during the sweep. Required: `dout_valid` stays 0. Assert `reset` at sweep cycle 5; `busy` must stay 1 for 16 further cycles.
- **Out of range:** build with `DEPTH`=12. Write to addr 1101, then read addr 1101. Required: `err`=1 on both; read gives `dataout`=0000 with `dout_valid`=1. Addr 0..11 are unaffected.
